// File: rtl/atm_pkg.sv
`default_nettype none
// ============================================================================
// atm_pkg : session states and operation encodings for atm_session_ctrl
// Rev 1.0 : initial release
// ============================================================================
package atm_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_LANG     = 4'd1,
        S_PIN      = 4'd2,
        S_HOME     = 4'd3,
        S_WD_AMT   = 4'd4,
        S_WD_CHK   = 4'd5,
        S_DEP_AMT  = 4'd6,
        S_DEP_DONE = 4'd7,
        S_BAL      = 4'd8,
        S_PINCHG   = 4'd9,
        S_EJECT    = 4'd10
    } state_t;

    localparam logic [1:0] OP_WD  = 2'b00;
    localparam logic [1:0] OP_DEP = 2'b01;
    localparam logic [1:0] OP_BAL = 2'b10;
    localparam logic [1:0] OP_PIN = 2'b11;

    function automatic logic is_active(input state_t s);
        return (s != S_IDLE) && (s != S_EJECT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/atm_acct_store.sv
`default_nettype none
// ============================================================================
// atm_acct_store : per-account balance / PIN / lock storage, one write port
// Rev 1.0 : initial release
// ============================================================================
module atm_acct_store
    import atm_pkg::*;
#(
    parameter int                NUM_ACCTS = 4,
    parameter int                ACCT_W    = 2,
    parameter int                PIN_W     = 4,
    parameter int                BAL_W     = 8,
    parameter int                INIT_BAL  = 50,
    parameter logic [PIN_W-1:0]  DEF_PIN   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ACCT_W-1:0] i_rd_idx,
    output logic [BAL_W-1:0]  o_bal,
    output logic [PIN_W-1:0]  o_pin,
    output logic              o_lock,
    input  logic [ACCT_W-1:0] i_wr_idx,
    input  logic              i_bal_we,
    input  logic [BAL_W-1:0]  i_bal_wd,
    input  logic              i_pin_we,
    input  logic [PIN_W-1:0]  i_pin_wd,
    input  logic              i_lock_set
);

    logic [BAL_W-1:0]     r_bal [NUM_ACCTS];
    logic [PIN_W-1:0]     r_pin [NUM_ACCTS];
    logic [NUM_ACCTS-1:0] r_lock;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ACCTS; i++) begin
                r_bal[i] <= BAL_W'(INIT_BAL);
                r_pin[i] <= DEF_PIN;
            end
            r_lock <= '0;
        end else begin
            if (i_bal_we)   r_bal[i_wr_idx]  <= i_bal_wd;
            if (i_pin_we)   r_pin[i_wr_idx]  <= i_pin_wd;
            if (i_lock_set) r_lock[i_wr_idx] <= 1'b1;
        end
    end

    assign o_bal  = r_bal[i_rd_idx];
    assign o_pin  = r_pin[i_rd_idx];
    assign o_lock = r_lock[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/atm_session_ctrl.sv
`default_nettype none
// ============================================================================
// atm_session_ctrl : multi-account ATM session FSM with lockout and timeout.
// Optional macro ATM_WD_LIMIT_EN adds a per-session withdrawal cap.
// Rev 1.0 : initial release
// ============================================================================
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int               NUM_ACCTS        = 4,
    parameter int               PIN_W            = 4,
    parameter int               BAL_W            = 8,
    parameter int               AMT_W            = 6,
    parameter int               MAX_TRIES        = 3,
    parameter int               TIMEOUT_CYC      = 255,
    parameter int               INIT_BAL         = 50,
    parameter logic [PIN_W-1:0] DEF_PIN          = 4'b1101,
`ifdef ATM_WD_LIMIT_EN
    parameter int               SESSION_WD_LIMIT = 40,
`endif
    localparam int              ACCT_W = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1,
    localparam int              TRY_W  = $clog2(MAX_TRIES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              card_in,
    input  logic [ACCT_W-1:0] acct_id,
    input  logic              lang_ok,
    input  logic              pin_vld,
    input  logic [PIN_W-1:0]  pin,
    input  logic              op_vld,
    input  logic [1:0]        op,
    input  logic              amt_vld,
    input  logic [AMT_W-1:0]  amt,
    input  logic              go_main,
    input  logic              cancel,
    output logic [BAL_W-1:0]  balance_out,
    output logic              balance_vld,
    output logic              dep_ok,
    output logic              dep_fail,
    output logic              wd_ok,
    output logic              wd_denied,
    output logic              pin_chg_ok,
    output logic [TRY_W-1:0]  tries,
    output logic              locked,
    output logic              eject,
    output logic              active
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    state_t            r_state, w_next;
    logic [ACCT_W-1:0] r_acct, w_rd_idx;
    logic [AMT_W-1:0]  r_amt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [TRY_W-1:0]  r_tries, w_tries_nxt, w_try_inc;

    logic [BAL_W-1:0]  w_rd_bal, w_bal_wd, w_amt_ext;
    logic [PIN_W-1:0]  w_rd_pin;
    logic              w_rd_lock;
    logic [BAL_W:0]    w_dep_sum;
    logic              w_any_in, w_to_hit, w_wd_allow;
    logic              w_latch_acct, w_latch_amt, w_bal_we, w_pin_we, w_lock_set;
    logic              w_bal_vld, w_dep_ok, w_dep_fail, w_wd_ok, w_wd_denied;
    logic              w_pin_chg_ok, w_locked, w_eject;

    logic [BAL_W-1:0]  r_balance_out;
    logic              r_balance_vld, r_dep_ok, r_dep_fail, r_wd_ok, r_wd_denied;
    logic              r_pin_chg_ok, r_locked, r_eject, r_active;

    // The lock check happens in the same cycle the card arrives, so IDLE reads acct_id directly.
    assign w_rd_idx = (r_state == S_IDLE) ? acct_id : r_acct;

    atm_acct_store #(
        .NUM_ACCTS (NUM_ACCTS),
        .ACCT_W    (ACCT_W),
        .PIN_W     (PIN_W),
        .BAL_W     (BAL_W),
        .INIT_BAL  (INIT_BAL),
        .DEF_PIN   (DEF_PIN)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (w_rd_idx),
        .o_bal      (w_rd_bal),
        .o_pin      (w_rd_pin),
        .o_lock     (w_rd_lock),
        .i_wr_idx   (r_acct),
        .i_bal_we   (w_bal_we),
        .i_bal_wd   (w_bal_wd),
        .i_pin_we   (w_pin_we),
        .i_pin_wd   (pin),
        .i_lock_set (w_lock_set)
    );

    assign w_amt_ext = BAL_W'(r_amt);
    assign w_dep_sum = {1'b0, w_rd_bal} + {1'b0, w_amt_ext};
    assign w_try_inc = r_tries + TRY_W'(1);
    assign w_any_in  = pin_vld | op_vld | amt_vld | lang_ok | go_main;
    assign w_to_hit  = is_active(r_state) && !w_any_in && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

`ifdef ATM_WD_LIMIT_EN
    localparam int ACC_W = BAL_W + 1;
    logic [ACC_W-1:0] r_accum;

    assign w_wd_allow = (w_amt_ext <= w_rd_bal) &&
                        ((int'(r_accum) + int'(r_amt)) <= SESSION_WD_LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  r_accum <= '0;
        else if (r_state == S_IDLE) r_accum <= '0;
        else if (w_wd_ok)          r_accum <= r_accum + ACC_W'(r_amt);
    end
`else
    assign w_wd_allow = (w_amt_ext <= w_rd_bal);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_tries_nxt  = r_tries;
        w_latch_acct = 1'b0;
        w_latch_amt  = 1'b0;
        w_bal_we     = 1'b0;
        w_bal_wd     = w_rd_bal;
        w_pin_we     = 1'b0;
        w_lock_set   = 1'b0;
        w_bal_vld    = 1'b0;
        w_dep_ok     = 1'b0;
        w_dep_fail   = 1'b0;
        w_wd_ok      = 1'b0;
        w_wd_denied  = 1'b0;
        w_pin_chg_ok = 1'b0;
        w_locked     = 1'b0;
        w_eject      = 1'b0;

        // Cancel and timeout pre-empt whatever the current state would do.
        if (is_active(r_state) && (cancel || w_to_hit)) begin
            w_next = S_EJECT;
        end else begin
            case (r_state)
                S_IDLE: if (card_in) begin
                    w_latch_acct = 1'b1;
                    w_tries_nxt  = '0;
                    if (w_rd_lock) begin
                        w_locked = 1'b1;
                        w_next   = S_EJECT;
                    end else begin
                        w_next   = S_LANG;
                    end
                end
                S_LANG: if (lang_ok) w_next = S_PIN;
                S_PIN: if (pin_vld) begin
                    if (pin == w_rd_pin) begin
                        w_next = S_HOME;
                    end else begin
                        w_tries_nxt = w_try_inc;
                        if (w_try_inc == TRY_W'(MAX_TRIES)) begin
                            w_lock_set = 1'b1;
                            w_locked   = 1'b1;
                            w_next     = S_EJECT;
                        end
                    end
                end
                S_HOME: if (op_vld) begin
                    case (op)
                        OP_WD:  w_next = S_WD_AMT;
                        OP_DEP: w_next = S_DEP_AMT;
                        OP_BAL: w_next = S_BAL;
                        OP_PIN: w_next = S_PINCHG;
                    endcase
                end
                S_WD_AMT: begin
                    if (go_main) begin
                        w_next = S_HOME;
                    end else if (amt_vld && (amt != '0)) begin
                        w_latch_amt = 1'b1;
                        w_next      = S_WD_CHK;
                    end
                end
                S_WD_CHK: begin
                    if (w_wd_allow) begin
                        w_bal_we = 1'b1;
                        w_bal_wd = w_rd_bal - w_amt_ext;
                        w_wd_ok  = 1'b1;
                        w_next   = S_HOME;
                    end else begin
                        w_wd_denied = 1'b1;
                        w_next      = S_WD_AMT;
                    end
                end
                S_DEP_AMT: begin
                    if (go_main) begin
                        w_next = S_HOME;
                    end else if (amt_vld && (amt != '0)) begin
                        w_latch_amt = 1'b1;
                        w_next      = S_DEP_DONE;
                    end
                end
                S_DEP_DONE: begin
                    if (!w_dep_sum[BAL_W]) begin
                        w_bal_we = 1'b1;
                        w_bal_wd = w_dep_sum[BAL_W-1:0];
                        w_dep_ok = 1'b1;
                    end else begin
                        w_dep_fail = 1'b1;
                    end
                    w_next = S_HOME;
                end
                S_BAL: begin
                    w_bal_vld = 1'b1;
                    w_next    = S_HOME;
                end
                S_PINCHG: begin
                    if (go_main) begin
                        w_next = S_HOME;
                    end else if (pin_vld) begin
                        w_pin_we     = 1'b1;
                        w_pin_chg_ok = 1'b1;
                        w_next       = S_HOME;
                    end
                end
                S_EJECT: begin
                    w_eject = 1'b1;
                    w_next  = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acct        <= '0;
            r_amt         <= '0;
            r_tries       <= '0;
            r_to_cnt      <= '0;
            r_balance_out <= '0;
            r_balance_vld <= 1'b0;
            r_dep_ok      <= 1'b0;
            r_dep_fail    <= 1'b0;
            r_wd_ok       <= 1'b0;
            r_wd_denied   <= 1'b0;
            r_pin_chg_ok  <= 1'b0;
            r_locked      <= 1'b0;
            r_eject       <= 1'b0;
            r_active      <= 1'b0;
        end else begin
            if (w_latch_acct) r_acct <= acct_id;
            if (w_latch_amt)  r_amt  <= amt;
            r_tries <= w_tries_nxt;
            if (!is_active(r_state) || w_any_in || (w_next != r_state))
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + TO_W'(1);
            if (w_bal_vld) r_balance_out <= w_rd_bal;
            r_balance_vld <= w_bal_vld;
            r_dep_ok      <= w_dep_ok;
            r_dep_fail    <= w_dep_fail;
            r_wd_ok       <= w_wd_ok;
            r_wd_denied   <= w_wd_denied;
            r_pin_chg_ok  <= w_pin_chg_ok;
            r_locked      <= w_locked;
            r_eject       <= w_eject;
            r_active      <= is_active(w_next);
        end
    end

    assign balance_out = r_balance_out;
    assign balance_vld = r_balance_vld;
    assign dep_ok      = r_dep_ok;
    assign dep_fail    = r_dep_fail;
    assign wd_ok       = r_wd_ok;
    assign wd_denied   = r_wd_denied;
    assign pin_chg_ok  = r_pin_chg_ok;
    assign tries       = r_tries;
    assign locked      = r_locked;
    assign eject       = r_eject;
    assign active      = r_active;

endmodule
`default_nettype wire

// File: tb/tb_atm_session_ctrl.sv
`default_nettype none
// ============================================================================
// tb_atm_session_ctrl : directed self-checking bench for atm_session_ctrl
// Rev 1.0 : initial release
// ============================================================================
module tb_atm_session_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       card_in = 1'b0;
    logic [1:0] acct_id = '0;
    logic       lang_ok = 1'b0;
    logic       pin_vld = 1'b0;
    logic [3:0] pin = '0;
    logic       op_vld = 1'b0;
    logic [1:0] op = '0;
    logic       amt_vld = 1'b0;
    logic [5:0] amt = '0;
    logic       go_main = 1'b0;
    logic       cancel = 1'b0;
    logic [7:0] balance_out;
    logic       balance_vld, dep_ok, dep_fail, wd_ok, wd_denied, pin_chg_ok;
    logic [1:0] tries;
    logic       locked, eject, active;

    int n_tests = 0;
    int n_fail  = 0;

    atm_session_ctrl dut (
        .clk(clk), .rst(rst), .card_in(card_in), .acct_id(acct_id),
        .lang_ok(lang_ok), .pin_vld(pin_vld), .pin(pin), .op_vld(op_vld),
        .op(op), .amt_vld(amt_vld), .amt(amt), .go_main(go_main),
        .cancel(cancel), .balance_out(balance_out), .balance_vld(balance_vld),
        .dep_ok(dep_ok), .dep_fail(dep_fail), .wd_ok(wd_ok),
        .wd_denied(wd_denied), .pin_chg_ok(pin_chg_ok), .tries(tries),
        .locked(locked), .eject(eject), .active(active)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic login(input logic [1:0] a, input logic [3:0] p);
        card_in = 1'b1; acct_id = a; cyc(); card_in = 1'b0;
        lang_ok = 1'b1; cyc(); lang_ok = 1'b0;
        pin_vld = 1'b1; pin = p; cyc(); pin_vld = 1'b0;
    endtask

    task automatic logout();
        cancel = 1'b1; cyc(); cancel = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic sel_op(input logic [1:0] o);
        op_vld = 1'b1; op = o; cyc(); op_vld = 1'b0;
    endtask

    task automatic enter_amt(input logic [5:0] a);
        amt_vld = 1'b1; amt = a; cyc(); amt_vld = 1'b0;
    endtask

    task automatic read_bal(output logic [7:0] b, output logic v);
        sel_op(2'b10);
        cyc();
        b = balance_out;
        v = balance_vld;
        cyc();
    endtask

    task automatic test_reset();
        logic [20:0] obs;
        rst = 1'b0;
        cyc(); cyc();
        obs = {balance_out, balance_vld, dep_ok, dep_fail, wd_ok, wd_denied,
               pin_chg_ok, tries, locked, eject, active};
        n_tests++;
        if (obs !== 21'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h required 0", obs);
        end
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_balance();
        logic [7:0] b; logic v;
        login(2'd2, 4'b1101);
        n_tests++;
        if (active !== 1'b1) begin
            n_fail++; $display("FAIL bal_active: got %b required 1", active);
        end
        read_bal(b, v);
        n_tests++;
        if ({v, b} !== {1'b1, 8'd50}) begin
            n_fail++; $display("FAIL bal_read: got vld=%b bal=%0d required vld=1 bal=50", v, b);
        end
        cancel = 1'b1; cyc(); cancel = 1'b0;
        n_tests++;
        if ({active, eject} !== 2'b00) begin
            n_fail++; $display("FAIL cancel_eject_state: got act/ej=%b required 00", {active, eject});
        end
        cyc();
        n_tests++;
        if ({active, eject} !== 2'b01) begin
            n_fail++; $display("FAIL cancel_eject_pulse: got act/ej=%b required 01", {active, eject});
        end
        cyc();
        n_tests++;
        if (eject !== 1'b0) begin
            n_fail++; $display("FAIL eject_one_cycle: got %b required 0", eject);
        end
    endtask

    task automatic test_withdraw();
        logic [7:0] b; logic v;
        login(2'd0, 4'b1101);
        sel_op(2'b00); enter_amt(6'd20); cyc();
        n_tests++;
        if ({wd_ok, wd_denied} !== 2'b10) begin
            n_fail++; $display("FAIL wd20_ok: got ok/den=%b required 10", {wd_ok, wd_denied});
        end
        sel_op(2'b00); enter_amt(6'd40); cyc();
        n_tests++;
        if ({wd_ok, wd_denied} !== 2'b01) begin
            n_fail++; $display("FAIL wd40_denied: got ok/den=%b required 01", {wd_ok, wd_denied});
        end
        enter_amt(6'd0); cyc();
        n_tests++;
        if ({wd_ok, wd_denied} !== 2'b00) begin
            n_fail++; $display("FAIL wd0_ignored: got ok/den=%b required 00", {wd_ok, wd_denied});
        end
        go_main = 1'b1; amt_vld = 1'b1; amt = 6'd5; cyc(); go_main = 1'b0; amt_vld = 1'b0;
        cyc();
        n_tests++;
        if ({wd_ok, wd_denied} !== 2'b00) begin
            n_fail++; $display("FAIL go_main_priority: got ok/den=%b required 00", {wd_ok, wd_denied});
        end
        read_bal(b, v);
        n_tests++;
        if ({v, b} !== {1'b1, 8'd30}) begin
            n_fail++; $display("FAIL wd_balance: got vld=%b bal=%0d required vld=1 bal=30", v, b);
        end
        logout();
    endtask

    task automatic test_deposit();
        logic [7:0] b; logic v;
        logic [5:0] dep_amt [5] = '{6'd60, 6'd60, 6'd63, 6'd17, 6'd63};
        logic [1:0] dep_res [5] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        logic [7:0] dep_bal [5] = '{8'd110, 8'd170, 8'd233, 8'd250, 8'd250};
        login(2'd1, 4'b1101);
        for (int i = 0; i < 5; i++) begin
            sel_op(2'b01); enter_amt(dep_amt[i]); cyc();
            n_tests++;
            if ({dep_ok, dep_fail} !== dep_res[i]) begin
                n_fail++; $display("FAIL dep_pulse[%0d]: got ok/fail=%b required %b", i, {dep_ok, dep_fail}, dep_res[i]);
            end
            read_bal(b, v);
            n_tests++;
            if ({v, b} !== {1'b1, dep_bal[i]}) begin
                n_fail++; $display("FAIL dep_balance[%0d]: got vld=%b bal=%0d required vld=1 bal=%0d", i, v, b, dep_bal[i]);
            end
        end
        logout();
    endtask

    task automatic test_lockout();
        logic [7:0] b; logic v;
        card_in = 1'b1; acct_id = 2'd3; cyc(); card_in = 1'b0;
        lang_ok = 1'b1; cyc(); lang_ok = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            pin_vld = 1'b1; pin = 4'b0000; cyc(); pin_vld = 1'b0;
            n_tests++;
            if ({tries, locked} !== {2'(i), (i == 3)}) begin
                n_fail++; $display("FAIL wrong_pin[%0d]: got tries=%0d locked=%b required tries=%0d locked=%b", i, tries, locked, i, (i == 3));
            end
        end
        cyc();
        n_tests++;
        if ({eject, locked} !== 2'b10) begin
            n_fail++; $display("FAIL lock_eject: got ej/lk=%b required 10", {eject, locked});
        end
        cyc();
        card_in = 1'b1; acct_id = 2'd3; cyc(); card_in = 1'b0;
        n_tests++;
        if ({locked, active} !== 2'b10) begin
            n_fail++; $display("FAIL relock: got lk/act=%b required 10", {locked, active});
        end
        cyc();
        n_tests++;
        if (eject !== 1'b1) begin
            n_fail++; $display("FAIL relock_eject: got %b required 1", eject);
        end
        cyc();
        login(2'd0, 4'b1101);
        read_bal(b, v);
        n_tests++;
        if ({active, tries, v, b} !== {1'b1, 2'd0, 1'b1, 8'd30}) begin
            n_fail++; $display("FAIL other_acct: got act=%b tries=%0d vld=%b bal=%0d required 1 0 1 30", active, tries, v, b);
        end
        logout();
    endtask

    task automatic test_timeout();
        login(2'd0, 4'b1101);
        repeat (254) cyc();
        pin_vld = 1'b1; pin = 4'b0000; cyc(); pin_vld = 1'b0;
        n_tests++;
        if (active !== 1'b1) begin
            n_fail++; $display("FAIL timeout_saved: got active=%b required 1", active);
        end
        repeat (254) cyc();
        n_tests++;
        if (active !== 1'b1) begin
            n_fail++; $display("FAIL timeout_early: got active=%b required 1", active);
        end
        cyc();
        n_tests++;
        if ({active, eject} !== 2'b00) begin
            n_fail++; $display("FAIL timeout_fire: got act/ej=%b required 00", {active, eject});
        end
        cyc();
        n_tests++;
        if (eject !== 1'b1) begin
            n_fail++; $display("FAIL timeout_eject: got %b required 1", eject);
        end
        cyc();
    endtask

    task automatic test_pin_change();
        logic [7:0] b; logic v;
        login(2'd2, 4'b1101);
        sel_op(2'b11);
        pin_vld = 1'b1; pin = 4'b0110; cyc(); pin_vld = 1'b0;
        n_tests++;
        if (pin_chg_ok !== 1'b1) begin
            n_fail++; $display("FAIL pin_chg_ok: got %b required 1", pin_chg_ok);
        end
        logout();
        login(2'd2, 4'b1101);
        n_tests++;
        if ({active, tries} !== {1'b1, 2'd1}) begin
            n_fail++; $display("FAIL old_pin_rejected: got act=%b tries=%0d required 1 1", active, tries);
        end
        pin_vld = 1'b1; pin = 4'b0110; cyc(); pin_vld = 1'b0;
        read_bal(b, v);
        n_tests++;
        if ({v, b} !== {1'b1, 8'd50}) begin
            n_fail++; $display("FAIL new_pin_accepted: got vld=%b bal=%0d required 1 50", v, b);
        end
        logout();
    endtask

`ifdef ATM_WD_LIMIT_EN
    task automatic test_wd_limit();
        login(2'd2, 4'b0110);
        sel_op(2'b00); enter_amt(6'd30); cyc();
        n_tests++;
        if ({wd_ok, wd_denied} !== 2'b10) begin
            n_fail++; $display("FAIL limit_wd30: got ok/den=%b required 10", {wd_ok, wd_denied});
        end
        sel_op(2'b00); enter_amt(6'd20); cyc();
        n_tests++;
        if ({wd_ok, wd_denied} !== 2'b01) begin
            n_fail++; $display("FAIL limit_wd20: got ok/den=%b required 01", {wd_ok, wd_denied});
        end
        go_main = 1'b1; cyc(); go_main = 1'b0;
        logout();
    endtask
`endif

    task automatic test_reset_mid();
        logic [7:0] b; logic v;
        login(2'd0, 4'b1101);
        sel_op(2'b00);
        rst = 1'b0;
        #1;
        n_tests++;
        if (active !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got active=%b required 0", active);
        end
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        login(2'd0, 4'b1101);
        read_bal(b, v);
        n_tests++;
        if ({v, b} !== {1'b1, 8'd50}) begin
            n_fail++; $display("FAIL reset_balance: got vld=%b bal=%0d required 1 50", v, b);
        end
        logout();
        login(2'd3, 4'b1101);
        n_tests++;
        if (active !== 1'b1) begin
            n_fail++; $display("FAIL reset_unlock: got active=%b required 1", active);
        end
        logout();
    endtask

    initial begin
        test_reset();
        test_balance();
        test_withdraw();
        test_deposit();
        test_lockout();
        test_timeout();
        test_pin_change();
`ifdef ATM_WD_LIMIT_EN
        test_wd_limit();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
